fifo_wr_ptr_full: RTL and testbench
===================================

Name: fifo_wr_ptr_full

Overview:
Write-domain pointer and full-flag stage of the asynchronous FIFO.
- Owns the binary and Gray write pointers.
- Drives the dual-port memory write address and enable.
- Exports the registered Gray write pointer to the read-domain two-flop synchronizer.
- Consumes the read pointer after it has been synchronized into the write domain; from it, derives FULL, fill level and overflow status.

Parameters:
ADDR_WIDTH, 5, memory address width; FIFO depth = 2**ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits
AF_THRESHOLD, 28, almost-full level (used only when WR_ALMOST_FULL_EN is defined); legal range 1..2**ADDR_WIDTH-1

Ports:
CLK  in  1  write-domain clock
RST  in  1  asynchronous active-low reset
W_INC  in  1  write request from producer, sampled on rising CLK
RD_PTR_SYNC  in  ADDR_WIDTH+1  Gray read pointer, already synchronized into the CLK domain
W_EN  out  1  memory write enable, = W_INC & ~FULL (combinational)
W_ADDR  out  ADDR_WIDTH  memory write address, = wbin[ADDR_WIDTH-1:0]
WR_PTR_GRAY  out  ADDR_WIDTH+1  registered Gray write pointer, to read-domain synchronizer
FULL  out  1  FIFO full, registered
W_LEVEL  out  ADDR_WIDTH+1  registered fill level as seen from the write side, 0..2**ADDR_WIDTH
OVERFLOW  out  1  sticky: a write was attempted while FULL
ALMOST_FULL  out  1  present only with WR_ALMOST_FULL_EN

Behaviour:
- Reset (RST=0, asynchronous):
  - Internal wbin = 0.
  - WR_PTR_GRAY = 0, FULL = 0, W_LEVEL = 0, OVERFLOW = 0, ALMOST_FULL = 0.
  - Reset asserted mid-operation discards all state immediately; the first rising CLK after release behaves as on an empty FIFO.
- Pointer advance:
  - wbin_next = wbin + W_EN, modulo 2**(ADDR_WIDTH+1).
  - wgray_next = wbin_next ^ (wbin_next >> 1).
  - wbin and WR_PTR_GRAY load wbin_next and wgray_next on every rising CLK. WR_PTR_GRAY therefore changes by exactly one bit per accepted write, with no combinational glitch on the crossing.
- W_ADDR is the pre-increment address: the data written at edge N lands at W_ADDR sampled before edge N.
- FULL:
  - Registered as FULL <= (wgray_next == {~RD_PTR_SYNC[ADDR_WIDTH:ADDR_WIDTH-1], RD_PTR_SYNC[ADDR_WIDTH-2:0]}).
  - Asserts on the same edge that accepts the write filling the last location.
  - Deasserts on the first edge after RD_PTR_SYNC advances. The freeing read is seen 2 write clocks later because of the synchronizer, so FULL is pessimistic and never optimistic.
- W_EN:
  - W_INC while FULL=1 gives W_EN=0; the pointer and memory are unchanged.
  - W_INC is ignored when FULL is high, even if a read has just been synchronized in the same cycle. The write is accepted on the following cycle, after FULL has dropped.
- W_LEVEL:
  - rbin = Gray-to-binary of RD_PTR_SYNC (bit i = XOR of Gray bits ADDR_WIDTH..i).
  - W_LEVEL <= wbin_next - rbin, modulo 2**(ADDR_WIDTH+1).
  - W_LEVEL = 2**ADDR_WIDTH exactly when FULL=1.
- OVERFLOW:
  - Set on any edge with W_INC=1 and FULL=1.
  - Held until reset; no other clear.
- Wrap-around: the pointer MSB toggles every 2**ADDR_WIDTH writes. Full/level arithmetic is modulo-correct across the wrap; there is no special case.

Optional Feature:
WR_ALMOST_FULL_EN
- Defined:
  - ALMOST_FULL port exists.
  - ALMOST_FULL <= (wbin_next - rbin) >= AF_THRESHOLD, registered, same timing as FULL.
  - ALMOST_FULL is also 1 whenever FULL is 1.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset, RD_PTR_SYNC=0, 32 consecutive W_INC -> W_ADDR 0..31; WR_PTR_GRAY sequence 0,1,3,2,6,...; FULL=1 and W_LEVEL=32 after the 32nd edge; WR_PTR_GRAY=6'b110000.
- FULL with W_INC held for 3 more cycles -> W_EN=0, WR_PTR_GRAY unchanged, OVERFLOW=1 and held after W_INC drops.
- From full, drive RD_PTR_SYNC=6'b000001 (read of 1) -> FULL=0 and W_LEVEL=31 after the next edge; the next W_INC is accepted at W_ADDR=0.
- 100 writes with RD_PTR_SYNC tracking the Gray of (writes-2) each cycle -> W_LEVEL stays 2, FULL never asserts, the pointer wraps past 63 to 0 cleanly, and exactly one WR_PTR_GRAY bit changes per write.
- After 10 writes, pulse RST low mid-cycle -> all outputs 0 immediately; the first write after release uses W_ADDR=0.
- With WR_ALMOST_FULL_EN and AF_THRESHOLD=28, RD_PTR_SYNC=0 -> ALMOST_FULL rises after the 28th write, stays 1 through FULL, and falls when RD_PTR_SYNC reflects a level of 27.

Source files
------------

// File: rtl/fifo_wr_ptr_full.sv
// Write-side pointer/full stage of the async FIFO: binary+Gray write pointer, FULL, level, sticky OVERFLOW.
// Optional ALMOST_FULL output is built when WR_ALMOST_FULL_EN is defined.
module fifo_wr_ptr_full #(
  parameter int ADDR_WIDTH   = 5,
  parameter int AF_THRESHOLD = 28
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  W_INC,
  input  logic [ADDR_WIDTH:0]   RD_PTR_SYNC,
  output logic                  W_EN,
  output logic [ADDR_WIDTH-1:0] W_ADDR,
  output logic [ADDR_WIDTH:0]   WR_PTR_GRAY,
  output logic                  FULL,
  output logic [ADDR_WIDTH:0]   W_LEVEL,
  output logic                  OVERFLOW
`ifdef WR_ALMOST_FULL_EN
  ,
  output logic                  ALMOST_FULL
`endif
);

  localparam int PW = ADDR_WIDTH + 1;

  if (AF_THRESHOLD < 1 || AF_THRESHOLD > (1 << ADDR_WIDTH) - 1) begin : g_bad_af
    $error("AF_THRESHOLD out of range");
  end

  logic [PW-1:0] wbin_reg;
  logic [PW-1:0] wbin_next;
  logic [PW-1:0] wgray_reg;
  logic [PW-1:0] wgray_next;
  logic [PW-1:0] rbin;
  logic [PW-1:0] level_next;
  logic [PW-1:0] full_gray;
  logic          full_reg;
  logic          full_next;
  logic [PW-1:0] level_reg;
  logic          overflow_reg;

  // Synchronized read pointer back to binary: each bit is the XOR of all Gray bits at or above it.
  for (genvar gi = 0; gi < PW; gi++) begin : g_rbin
    assign rbin[gi] = ^RD_PTR_SYNC[ADDR_WIDTH:gi];
  end

  assign W_EN       = W_INC & ~full_reg;
  assign wbin_next  = wbin_reg + {{ADDR_WIDTH{1'b0}}, W_EN};
  assign wgray_next = wbin_next ^ (wbin_next >> 1);
  assign level_next = wbin_next - rbin;

  // Full when the write pointer is one lap ahead: top two Gray bits inverted, rest equal.
  assign full_gray  = {~RD_PTR_SYNC[ADDR_WIDTH:ADDR_WIDTH-1], RD_PTR_SYNC[ADDR_WIDTH-2:0]};
  assign full_next  = (wgray_next == full_gray);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wbin_reg     <= '0;
      wgray_reg    <= '0;
      full_reg     <= 1'b0;
      level_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      wbin_reg     <= wbin_next;
      wgray_reg    <= wgray_next;
      full_reg     <= full_next;
      level_reg    <= level_next;
      overflow_reg <= overflow_reg | (W_INC & full_reg);
    end
  end

`ifdef WR_ALMOST_FULL_EN
  localparam logic [PW-1:0] AF_LEVEL = PW'(AF_THRESHOLD);

  logic af_reg;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      af_reg <= 1'b0;
    end else begin
      af_reg <= (level_next >= AF_LEVEL) | full_next;
    end
  end

  assign ALMOST_FULL = af_reg;
`endif

  assign W_ADDR      = wbin_reg[ADDR_WIDTH-1:0];
  assign WR_PTR_GRAY = wgray_reg;
  assign FULL        = full_reg;
  assign W_LEVEL     = level_reg;
  assign OVERFLOW    = overflow_reg;

endmodule

// File: tb/tb_fifo_wr_ptr_full.sv
// Scoreboard bench for fifo_wr_ptr_full: stimulus pushes expected state, a monitor pops and compares.
module tb_fifo_wr_ptr_full;

  localparam int AW    = 5;
  localparam int DEPTH = 1 << AW;
  localparam int AF    = 28;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          W_INC = 1'b0;
  logic [AW:0]   RD_PTR_SYNC = '0;
  logic          W_EN;
  logic [AW-1:0] W_ADDR;
  logic [AW:0]   WR_PTR_GRAY;
  logic          FULL;
  logic [AW:0]   W_LEVEL;
  logic          OVERFLOW;
`ifdef WR_ALMOST_FULL_EN
  logic          ALMOST_FULL;
`endif

  fifo_wr_ptr_full #(.ADDR_WIDTH(AW), .AF_THRESHOLD(AF)) dut (
    .CLK(CLK), .RST(RST), .W_INC(W_INC), .RD_PTR_SYNC(RD_PTR_SYNC),
    .W_EN(W_EN), .W_ADDR(W_ADDR), .WR_PTR_GRAY(WR_PTR_GRAY), .FULL(FULL),
    .W_LEVEL(W_LEVEL), .OVERFLOW(OVERFLOW)
`ifdef WR_ALMOST_FULL_EN
    , .ALMOST_FULL(ALMOST_FULL)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic          w_en;
    logic [AW-1:0] w_addr;
    logic [AW:0]   gray;
    logic          full;
    logic [AW:0]   level;
    logic          ovf;
    logic          af;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: counts of writes accepted and reads reported, plain modular arithmetic.
  int m_writes;   // total accepted writes, unbounded
  int m_reads;    // read position conveyed by RD_PTR_SYNC, unbounded
  bit m_full, m_ovf, m_af;
  int m_level;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [AW:0] to_gray(input int n);
    logic [AW:0] b;
    b = AW'(0) + (n % (2 * DEPTH));
    return b ^ (b >> 1);
  endfunction

  task automatic model_reset();
    m_writes = 0; m_reads = 0; m_full = 0; m_ovf = 0; m_af = 0; m_level = 0;
  endtask

  // One cycle: drive inputs at the falling edge, record what the DUT must show now,
  // then advance the model across the coming rising edge.
  task automatic step(input bit inc, input int reads, input bit rst_n);
    exp_t e;
    bit   acc;
    @(negedge CLK);
    W_INC       = inc;
    RD_PTR_SYNC = to_gray(reads);
    RST         = rst_n;
    if (!rst_n) model_reset();
    e.w_en   = inc && !m_full;
    e.w_addr = AW'(m_writes % DEPTH);
    e.gray   = to_gray(m_writes);
    e.full   = m_full;
    e.level  = (AW + 1)'(m_level);
    e.ovf    = m_ovf;
    e.af     = m_af;
    exp_q.push_back(e);
    if (rst_n) begin
      acc      = inc && !m_full;
      m_ovf    = m_ovf || (inc && m_full);
      m_writes = m_writes + int'(acc);
      m_reads  = reads;
      m_level  = m_writes - m_reads;
      m_full   = (m_level == DEPTH);
      m_af     = (m_level >= AF);
    end
    $display("cycle t=%0t rst=%0b inc=%0b reads=%0d -> exp addr=%0d w_en=%0b gray=%0h full=%0b level=%0d ovf=%0b",
             $time, rst_n, inc, reads, e.w_addr, e.w_en, e.gray, e.full, e.level, e.ovf);
  endtask

  // Monitor: samples 2 time units after the falling edge, once inputs have settled.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("w_en",     int'(W_EN),        int'(e.w_en));
        chk("w_addr",   int'(W_ADDR),      int'(e.w_addr));
        chk("wr_gray",  int'(WR_PTR_GRAY), int'(e.gray));
        chk("full",     int'(FULL),        int'(e.full));
        chk("w_level",  int'(W_LEVEL),     int'(e.level));
        chk("overflow", int'(OVERFLOW),    int'(e.ovf));
`ifdef WR_ALMOST_FULL_EN
        chk("alm_full", int'(ALMOST_FULL), int'(e.af));
`endif
      end
    end
  end

  initial begin
    int rd;
    model_reset();
    // Reset state
    repeat (3) step(1'b0, 0, 1'b0);
    // Fill 32 locations, then 3 writes against FULL, then idle
    for (int i = 0; i < DEPTH; i++) step(1'b1, 0, 1'b1);
    repeat (3) step(1'b1, 0, 1'b1);
    repeat (2) step(1'b0, 0, 1'b1);
    // Read of one frees a slot; next write lands at address 0
    step(1'b0, 1, 1'b1);
    step(1'b1, 1, 1'b1);
    step(1'b0, 1, 1'b1);
    step(1'b0, 5, 1'b1);
    step(1'b0, 6, 1'b1);
    step(1'b0, 6, 1'b1);
    // Fresh start, 100 writes with read pointer trailing, wraps past 63
    step(1'b0, 0, 1'b0);
    for (int i = 0; i < 100; i++) step(1'b1, (m_writes > 0) ? m_writes - 1 : 0, 1'b1);
    step(1'b0, m_writes, 1'b1);
    // 10 writes then asynchronous reset mid-cycle; first write after release uses address 0
    step(1'b0, 0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 0, 1'b1);
    step(1'b1, 0, 1'b0);
    step(1'b1, 0, 1'b1);
    step(1'b1, 0, 1'b1);
    // Randomized traffic, reads never overtake writes
    rd = 0;
    step(1'b0, 0, 1'b0);
    for (int i = 0; i < 400; i++) begin
      if (rd < m_writes && $urandom_range(0, 99) < ((i % 200) < 100 ? 30 : 70)) rd++;
      step(1'($urandom_range(0, 99) < 60), rd, 1'b1);
    end
    step(1'b0, rd, 1'b1);
    step(1'b0, rd, 1'b1);
    @(negedge CLK);
    #4;
    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
